// File: rtl/rr_priority_arbiter8_if.sv
// Request/grant bundle between eight requesters and the shared-resource arbiter.
interface rr_priority_arbiter8_if #(
    parameter int NUM_REQ = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         gnt;
    logic [$clog2(NUM_REQ)-1:0] gnt_id;
    logic                       gnt_valid;
    logic                       timeout;

    modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_priority_arbiter8.sv
// Eight-way arbiter: rotating (or fixed) descending priority search, grant held
// while the winner keeps requesting, optional forced revoke after MAX_HOLD cycles.

// One requester's slice of the search: wins when it requests and no requester
// ranked earlier in the current search order is also requesting.
module rr_priority_arbiter8_lane #(
    parameter int NUM_REQ = 8,
    parameter int IDX     = 0
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       win
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] my_rank;
    logic [PW-1:0] rk;
    logic          blocked;

    // Rank 0 is searched first; order is ptr-1, ptr-2, ... wrapping modulo NUM_REQ.
    always_comb begin
        my_rank = ptr - PW'(IDX) - PW'(1);
        rk      = '0;
        blocked = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rk = ptr - PW'(k) - PW'(1);
            if (k != IDX && req[k] && rk < my_rank)
                blocked = 1'b1;
        end
        win = req[IDX] && !blocked;
    end
endmodule

module rr_priority_arbiter8 #(
    parameter int FIXED_PRI = 0,
    parameter int MAX_HOLD  = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    rr_priority_arbiter8_if.slave bus
);
    localparam int NUM_REQ = 8;
    localparam int IDW     = $clog2(NUM_REQ);
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               vld_q, vld_d;
    logic               to_q, to_d;

    logic [IDW-1:0]     srch_ptr;
    logic [NUM_REQ-1:0] win;
    logic [IDW-1:0]     win_id;
    logic               hold_hit;

    // Fixed mode searches as if the pointer never moved off 0 (order 7..0).
    assign srch_ptr = (FIXED_PRI != 0) ? '0 : ptr_q;
    assign hold_hit = (MAX_HOLD != 0) && (cnt_q == MAX_HOLD_C);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        rr_priority_arbiter8_lane #(.NUM_REQ(NUM_REQ), .IDX(i)) u_lane (
            .req (bus.req),
            .ptr (srch_ptr),
            .win (win[i])
        );
    end

    // One-hot winner to binary index.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win[i]) win_id = IDW'(i);
    end

    // State and grant registers; reset drops any grant without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

    // Next state: every grant ends in IDLE, either by release or by revoke.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (|bus.req) state_d = GRANT;
            GRANT: if (!bus.req[id_q] || hold_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant/counter/pointer values; release takes precedence over revoke.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        gnt_d = gnt_q;
        id_d  = id_q;
        vld_d = vld_q;
        to_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    ptr_d = win_id;
                    cnt_d = 8'd1;
                    gnt_d = win;
                    id_d  = win_id;
                    vld_d = 1'b1;
                end
            end
            GRANT: begin
                if (state_d == IDLE) begin
                    gnt_d = '0;
                    vld_d = 1'b0;
                    cnt_d = '0;
                    to_d  = bus.req[id_q];
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_priority_arbiter8.sv
// Directed bench for rr_priority_arbiter8: three configurations run side by side
// against a behavioural model, plus literal expectations for each scenario.
module tb_rr_priority_arbiter8;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rr_priority_arbiter8_if if_f ();
    rr_priority_arbiter8_if if_r ();
    rr_priority_arbiter8_if if_t ();

    rr_priority_arbiter8 #(.FIXED_PRI(1), .MAX_HOLD(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));
    rr_priority_arbiter8 #(.FIXED_PRI(0), .MAX_HOLD(0)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));
    rr_priority_arbiter8 #(.FIXED_PRI(0), .MAX_HOLD(4)) u_to  (.clk(clk), .rst_n(rst_n), .bus(if_t.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        bit busy;
        int id;
        int cnt;
        int ptr;
        bit to;
    } mdl_t;

    mdl_t m_f, m_r, m_t;

    // Arbiter behaviour described by its rules, one clock step at a time.
    function automatic mdl_t mstep(mdl_t s, logic [7:0] r, bit fixed, int maxh);
        mdl_t n;
        bit   found;
        int   idx;
        n     = s;
        n.to  = 0;
        found = 0;
        if (!s.busy) begin
            for (int k = 1; k <= 8; k++) begin
                idx = fixed ? (8 - k) : ((s.ptr + 8 - k) % 8);
                if (!found && r[idx]) begin
                    found  = 1;
                    n.busy = 1;
                    n.id   = idx;
                    n.ptr  = idx;
                    n.cnt  = 1;
                end
            end
        end else if (!r[s.id]) begin
            n.busy = 0;
            n.cnt  = 0;
        end else if (maxh != 0 && s.cnt == maxh) begin
            n.busy = 0;
            n.cnt  = 0;
            n.to   = 1;
        end else begin
            n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_f <= '0; else m_f <= mstep(m_f, if_f.req, 1'b1, 0);
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_r <= '0; else m_r <= mstep(m_r, if_r.req, 1'b0, 0);
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_t <= '0; else m_t <= mstep(m_t, if_t.req, 1'b0, 4);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input logic [7:0] g, input logic [2:0] id,
                            input logic v, input logic to, input mdl_t m);
        chk({nm, " gnt"}, int'(g), m.busy ? (1 << m.id) : 0);
        chk({nm, " gnt_valid"}, int'(v), int'(m.busy));
        chk({nm, " timeout"}, int'(to), int'(m.to));
        if (m.busy) chk({nm, " gnt_id"}, int'(id), m.id);
    endtask

    // Every falling edge: all three DUTs against the model.
    always @(negedge clk) begin
        cmp_inst("fix", if_f.gnt, if_f.gnt_id, if_f.gnt_valid, if_f.timeout, m_f);
        cmp_inst("rr",  if_r.gnt, if_r.gnt_id, if_r.gnt_valid, if_r.timeout, m_r);
        cmp_inst("to",  if_t.gnt, if_t.gnt_id, if_t.gnt_valid, if_t.timeout, m_t);
    end

    // Hand-computed expectation applied to both the DUT and the model.
    task automatic lit(input string nm, input logic [7:0] g, input mdl_t m, input int exp);
        chk({nm, " dut"}, int'(g), exp);
        chk({nm, " model"}, m.busy ? (1 << m.id) : 0, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        if_f.req = 8'h00;
        if_r.req = 8'h00;
        if_t.req = 8'h00;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, expected finish before 200000");
        $fatal(1);
    end

    int rr_seq [9];
    int tg [11];
    int tt [11];

    initial begin
        rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        tg     = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80};
        tt     = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

        // Reset held with every requester asserted.
        rst_n    = 1'b0;
        if_f.req = 8'hFF;
        if_r.req = 8'hFF;
        if_t.req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            lit("rst fix gnt", if_f.gnt, m_f, 8'h00);
            chk("rst rr gnt", int'(if_r.gnt), 0);
            chk("rst gnt_valid", int'(if_t.gnt_valid), 0);
            chk("rst timeout", int'(if_t.timeout), 0);
            chk("rst gnt_id", int'(if_f.gnt_id), 0);
        end
        rst_n = 1'b1;
        cyc();
        lit("post-rst fix", if_f.gnt, m_f, 8'h80);
        lit("post-rst rr", if_r.gnt, m_r, 8'h80);
        chk("post-rst id", int'(if_t.gnt_id), 7);

        // Fixed priority: 5 wins, holds, then 2 after one dead cycle.
        do_reset();
        if_f.req = 8'b0010_0110;
        cyc(); lit("fix first", if_f.gnt, m_f, 8'h20);
        chk("fix id5", int'(if_f.gnt_id), 5);
        cyc(); lit("fix hold", if_f.gnt, m_f, 8'h20);
        if_f.req = 8'b0000_0110;
        cyc(); lit("fix release", if_f.gnt, m_f, 8'h00);
        cyc(); lit("fix second", if_f.gnt, m_f, 8'h04);
        chk("fix id2", int'(if_f.gnt_id), 2);

        // Round-robin rotation with each winner dropping for one cycle.
        do_reset();
        if_r.req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            cyc(); lit($sformatf("rr grant%0d", n), if_r.gnt, m_r, 1 << rr_seq[n]);
            cyc(); lit($sformatf("rr hold%0d", n), if_r.gnt, m_r, 1 << rr_seq[n]);
            if_r.req = 8'hFF & ~(8'h01 << rr_seq[n]);
            cyc(); lit($sformatf("rr gap%0d", n), if_r.gnt, m_r, 8'h00);
            if_r.req = 8'hFF;
        end

        // MAX_HOLD=4 with two continuous requesters.
        do_reset();
        if_t.req = 8'h81;
        for (int i = 0; i < 11; i++) begin
            cyc();
            lit($sformatf("to gnt%0d", i), if_t.gnt, m_t, tg[i]);
            chk($sformatf("to pulse%0d", i), int'(if_t.timeout), tt[i]);
        end

        // Release on the same edge the hold limit is reached: no pulse.
        do_reset();
        if_t.req = 8'h80;
        for (int i = 0; i < 4; i++) cyc();
        lit("rel@limit hold", if_t.gnt, m_t, 8'h80);
        if_t.req = 8'h00;
        cyc();
        lit("rel@limit gnt", if_t.gnt, m_t, 8'h00);
        chk("rel@limit timeout", int'(if_t.timeout), 0);

        // No pre-emption by a higher-priority late request.
        do_reset();
        if_f.req = 8'h02;
        cyc(); lit("npe first", if_f.gnt, m_f, 8'h02);
        if_f.req = 8'h82;
        cyc(); lit("npe hold1", if_f.gnt, m_f, 8'h02);
        cyc(); lit("npe hold2", if_f.gnt, m_f, 8'h02);
        if_f.req = 8'h80;
        cyc(); lit("npe release", if_f.gnt, m_f, 8'h00);
        cyc(); lit("npe next", if_f.gnt, m_f, 8'h80);

        // Asynchronous reset between edges while granting index 4.
        do_reset();
        if_r.req = 8'h10;
        cyc(); lit("arst before", if_r.gnt, m_r, 8'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst gnt", int'(if_r.gnt), 0);
        chk("arst gnt_valid", int'(if_r.gnt_valid), 0);
        if_r.req = 8'hFF;
        cyc();
        rst_n = 1'b1;
        cyc(); lit("arst restart", if_r.gnt, m_r, 8'h80);

        if_f.req = 8'h00;
        if_r.req = 8'h00;
        if_t.req = 8'h00;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
